bto: RTL
========

# bto

Bus timeout monitor placed between the CPU bus master port and the address decoder/data-acknowledge multiplexers. It passes every access straight through, counts cycles while an access is outstanding, and terminates any access unacknowledged after a programmable limit with a synthetic acknowledge and zero read data. It records the faulting address and raises an interrupt, so accesses to unmapped or dead address space no longer hang the CPU. It also decodes as a small I/O device with four registers at 0x3080_0000 (`bus_addr[27:20] == 8'h08`).

## Interface
- `LIMIT_RST`, 1024: reset value of the LIMIT register, in clock cycles.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; asynchronous, active-high.
- `m_stb`  in  1  CPU bus strobe.
- `m_we`  in  1  CPU write enable.
- `m_addr`  in  30  CPU word address [31:2].
- `m_din`  out  32  read data to CPU.
- `m_ack`  out  1  acknowledge to CPU.
- `s_stb`  out  1  strobe to address decoder; equals `m_stb`.
- `s_din`  in  32  read data from the data multiplexer.
- `s_ack`  in  1  acknowledge from the acknowledge multiplexer.
- `stb`  in  1  register-slot strobe from the decoder.
- `we`  in  1  register write enable.
- `addr`  in  2  register select [3:2].
- `data_in`  in  32  register write data.
- `data_out`  out  32  register read data.
- `ack`  out  1  register acknowledge.
- `irq`  out  1  interrupt request, wired to `bus_irq[13]`.

## Operation
- Registers (word offsets):
  - 0 CTRL: bit0 = IEN, reset 0; other bits read 0.
  - 1 STATUS: bit0 = TMO, bit1 = OVR, reset 0. Any write clears both bits; write data is ignored.
  - 2 FADDR: read-only. Bits [31:2] = faulting address, bit0 = faulting `we`, bit1 = 0. Reset 0.
  - 3 LIMIT: bits [15:0], reset `LIMIT_RST`. A value of 0 disables timeouts. Bits [31:16] are ignored on write and read 0.
- Register access is zero-wait: `ack = stb`, `data_out` is combinational from `addr`.
- Counter `cnt` (16 bit):
  - Cleared when `m_stb == 0`, when `s_ack == 1`, or in the cycle after a timeout pulse.
  - Otherwise increments each cycle.
- Timeout pulse `tmo_p` (registered) is set at the edge where all of the following hold:
  - `m_stb == 1`
  - `s_ack == 0`
  - `LIMIT != 0`
  - `cnt == LIMIT-1`
  - `tmo_p == 0`
- `tmo_p` clears at the next edge.
- Pass-through:
  - `m_ack = s_ack | (tmo_p & m_stb)`.
  - `m_din = s_ack ? s_din : (tmo_p ? 0 : s_din)`.
- Fault recording, at the edge ending a cycle with `tmo_p & m_stb & ~s_ack`:
  - If TMO = 0: set TMO and capture `m_addr`/`m_we` into FADDR.
  - If TMO = 1: set OVR; FADDR is unchanged.
- If `s_ack` and `tmo_p` coincide, the real acknowledge wins: real data is returned and no fault is recorded.
- `irq = TMO & IEN`.
- Software clears STATUS and the capture of a new fault in the same edge: the new fault wins (TMO = 1, FADDR updated, OVR = 0).
- A LIMIT write mid-access takes effect from the next cycle. If the current `cnt` is already ≥ the new LIMIT-1, no timeout fires until `cnt` wraps at 2^16.

## Timing
- Cycle 0 is the first cycle with `m_stb` high. With no `s_ack`, `tmo_p` is high in cycle LIMIT, so `m_ack` is asserted in cycle LIMIT.
- Back-to-back access (`m_stb` stays high after a timeout ack): `cnt` is 0 in the following cycle and counting restarts.
- Pass-through paths add no latency: `s_stb`, `m_ack`, and `m_din` are combinational from `s_*`.
- Reset mid-access: `cnt`, `tmo_p`, and all registers return to reset values immediately; `m_ack` drops unless `s_ack` is high.

## Structure
- Shared include `bto_defs.v`:
  - register offsets (0–3)
  - STATUS bit positions
  - `LIMIT_RST` default
  - I/O slot value 8'h08
- Single flat module; no sub-module.
- Top-level changes:
  - The CPU drives `m_*`; the decoder and multiplexers consume `s_stb` and produce `s_din`/`s_ack`.
  - `bto_stb` is added to both multiplexers.

## Test plan
- Read 0x3000_0000 (tmr0), acknowledged in cycle 0 → `m_ack` in cycle 0 with tmr data; STATUS stays 0.
- LIMIT = 8, read 0x3F00_0000 (unmapped) → `m_ack` in cycle 8 with `m_din` = 0. STATUS = 1, FADDR = 0x3F00_0000, `irq` stays 0 while IEN = 0; writing CTRL = 1 raises `irq`.
- Second unmapped write to 0x3E00_0004 without clearing → STATUS = 3, FADDR still 0x3F00_0000. Then write STATUS → STATUS = 0 and `irq` low.
- LIMIT = 4, slave acks in cycle 4, the same cycle as `tmo_p` → real data returned, STATUS = 0.
- LIMIT = 0, unmapped read held for 70000 cycles → no `m_ack`. Assert `rst` mid-access → all outputs at reset values; LIMIT reads back 1024.
- Back-to-back unmapped reads with LIMIT = 3 → `m_ack` in cycles 3 and 7.

Source files
------------

// File: rtl/bto_pkg.sv
// Shared definitions for the bus timeout monitor: register map, STATUS bit
// layout, default timeout limit and the I/O slot the block decodes at.
package bto_pkg;

    localparam int unsigned LIMIT_W = 16;

    // Default timeout in clock cycles (about 20 us at 50 MHz)
    localparam logic [LIMIT_W-1:0] LIMIT_RST_DEF = 16'd1024;

    // bus_addr[27:20] value of the register slot (0x3080_0000)
    localparam logic [7:0] IO_SLOT = 8'h08;

    // Register word offsets
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_FADDR  = 2'd2,
        REG_LIMIT  = 2'd3
    } reg_sel_e;

    // STATUS bit positions
    localparam int unsigned STS_TMO = 0;
    localparam int unsigned STS_OVR = 1;

    typedef struct packed {
        logic ovr;
        logic tmo;
    } status_t;

    // FADDR read layout: word address in [31:2], bit1 zero, bit0 = faulting we
    function automatic logic [31:0] faddr_word(input logic [29:0] a, input logic w);
        return {a, 1'b0, w};
    endfunction

endpackage

// File: rtl/bto.sv
// Bus timeout monitor. Sits between the CPU master port and the decoder /
// acknowledge multiplexers, passes accesses through untouched, and ends any
// access left unacknowledged for LIMIT cycles with a synthetic ack and zero
// read data. The first fault is latched in FADDR and raises irq; later faults
// only set OVR until software clears STATUS.
module bto
    import bto_pkg::*;
#(
    parameter logic [LIMIT_W-1:0] LIMIT_RST = LIMIT_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    // CPU side
    input  logic        m_stb,
    input  logic        m_we,
    input  logic [29:0] m_addr,
    output logic [31:0] m_din,
    output logic        m_ack,
    // decoder / multiplexer side
    output logic        s_stb,
    input  logic [31:0] s_din,
    input  logic        s_ack,
    // register slot
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);

    // Register state
    logic               ien;
    status_t            sts;
    logic [29:0]        faddr;
    logic               fwe;
    logic [LIMIT_W-1:0] limit;

    // Timeout machinery
    logic [LIMIT_W-1:0] cnt;
    logic               tmo_p;

    reg_sel_e sel;
    logic     wr;
    logic     wr_ctrl;
    logic     wr_sts;
    logic     wr_lim;
    logic     fault;
    logic     tmo_hit;
    logic     cnt_clr;

    // Upper write-data bits have no home in any register
    logic unused_wdata;
    assign unused_wdata = ^data_in[31:LIMIT_W];

    assign sel     = reg_sel_e'(addr);
    assign wr      = stb & we;
    assign wr_ctrl = wr && (sel == REG_CTRL);
    assign wr_sts  = wr && (sel == REG_STATUS);
    assign wr_lim  = wr && (sel == REG_LIMIT);

    // A synthetic ack only counts as a fault if the real slave stayed silent
    assign fault   = tmo_p & m_stb & ~s_ack;

    // Fire once when the count reaches LIMIT-1; tmo_p itself blocks a retrigger
    assign tmo_hit = m_stb & ~s_ack & (limit != '0) &
                     (cnt == limit - LIMIT_W'(1)) & ~tmo_p;

    // The count restarts whenever the access ends, either way
    assign cnt_clr = ~m_stb | s_ack | tmo_p;

    // Pass-through: no added latency on strobe, ack or read data
    assign s_stb = m_stb;
    assign m_ack = s_ack | (tmo_p & m_stb);
    assign m_din = (!s_ack && tmo_p) ? '0 : s_din;

    // Register slot is zero-wait
    assign ack = stb;
    assign irq = sts.tmo & ien;

    // Outstanding-access cycle counter and one-cycle timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            tmo_p <= 1'b0;
        end else begin
            cnt   <= cnt_clr ? '0 : cnt + LIMIT_W'(1);
            tmo_p <= tmo_hit;
        end
    end

    // Software-writable control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien   <= 1'b0;
            limit <= LIMIT_RST;
        end else begin
            if (wr_ctrl)
                ien <= data_in[0];
            if (wr_lim)
                limit <= data_in[LIMIT_W-1:0];
        end
    end

    // Fault capture; a fault arriving with a STATUS clear is kept as a fresh one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sts   <= '0;
            faddr <= '0;
            fwe   <= 1'b0;
        end else if (fault && (!sts.tmo || wr_sts)) begin
            sts.tmo <= 1'b1;
            sts.ovr <= 1'b0;
            faddr   <= m_addr;
            fwe     <= m_we;
        end else if (fault) begin
            sts.ovr <= 1'b1;
        end else if (wr_sts) begin
            sts <= '0;
        end
    end

    // Register read mux
    always_comb begin
        data_out = '0;
        unique case (sel)
            REG_CTRL:   data_out[0] = ien;
            REG_STATUS: begin
                data_out[STS_TMO] = sts.tmo;
                data_out[STS_OVR] = sts.ovr;
            end
            REG_FADDR:  data_out = faddr_word(faddr, fwe);
            REG_LIMIT:  data_out[LIMIT_W-1:0] = limit;
            default:    data_out = '0;
        endcase
    end

endmodule
